// File: rtl/poly_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
package poly_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Widest accumulator the saturate helper accepts.
  localparam int MAXW = 128;

  typedef struct packed {
    logic [MAXW-1:0] value;
    logic            ovf;
  } sat_t;

  function automatic int acc_width(input int cw, input int xw, input int degree);
    return cw + degree * xw;
  endfunction

  // Range-check a sign-extended accumulator against a yw-bit signed result.
  // In wrap mode the value passes through and the caller keeps the low bits.
  function automatic sat_t saturate(input logic signed [MAXW-1:0] acc, input int yw,
                                    input logic sat_mode);
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    sat_t r;
    hi      = $signed((MAXW'(1) << (yw - 1)) - MAXW'(1));
    lo      = ~hi;
    r.value = acc;
    r.ovf   = 1'b0;
    if (acc > hi) begin
      r.ovf = 1'b1;
      if (sat_mode) r.value = hi;
    end else if (acc < lo) begin
      r.ovf = 1'b1;
      if (sat_mode) r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/poly_horner_eval_mac.sv
// One Horner step: acc*x + c, all at accumulator width.
module poly_mac_step #(
  parameter int ACCW = 32,
  parameter int XW   = 8,
  parameter int CW   = 16
) (
  input  logic signed [ACCW-1:0] i_acc,
  input  logic signed [XW-1:0]   i_x,
  input  logic signed [CW-1:0]   i_c,
  output logic signed [ACCW-1:0] o_res
);

  logic signed [ACCW-1:0] w_x_ext;
  logic signed [ACCW-1:0] w_c_ext;

  assign w_x_ext = {{(ACCW-XW){i_x[XW-1]}}, i_x};
  assign w_c_ext = {{(ACCW-CW){i_c[CW-1]}}, i_c};
  // Low ACCW bits of the product are exact; ACCW is sized so nothing is lost.
  assign o_res   = i_acc * w_x_ext + w_c_ext;

endmodule

// File: rtl/poly_horner_eval.sv
// Signed polynomial evaluator, one Horner multiply-accumulate per clock,
// with wrap/saturate output and overflow flag.
module poly_horner_eval
  import poly_pkg::*;
#(
  parameter int XW     = 8,
  parameter int CW     = 16,
  parameter int YW     = 16,
  parameter int DEGREE = 2,
  localparam int DW    = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [XW-1:0]        x,
  input  logic [(DEGREE+1)*CW-1:0]    coef,
  input  logic [DW-1:0]               deg,
  input  logic                        sat,
  input  logic                        enable,
  output logic signed [YW-1:0]        y,
  output logic                        ready,
  output logic                        valid,
  output logic                        ovf
);

  localparam int ACCW = acc_width(CW, XW, DEGREE);

  state_t                     r_state, w_state_next;
  logic [(DEGREE+1)*CW-1:0]   r_coef;
  logic signed [XW-1:0]       r_x;
  logic                       r_sat;
  logic [DW-1:0]              r_idx;
  logic signed [ACCW-1:0]     r_acc;
  logic signed [YW-1:0]       r_y;
  logic                       r_valid;
  logic                       r_ovf;

  logic [DW-1:0]              w_deg_clamp;
  logic [DW-1:0]              w_sel;
  logic signed [CW-1:0]       w_cin  [0:DEGREE];
  logic signed [CW-1:0]       w_creg [0:DEGREE];
  logic signed [CW-1:0]       w_start_c;
  logic signed [ACCW-1:0]     w_mac;
  logic signed [MAXW-1:0]     w_acc_ext;
  sat_t                       w_sat;
  logic                       w_start, w_step, w_finish;
  logic                       unused_sat_bits;

  genvar gi;
  generate
    for (gi = 0; gi <= DEGREE; gi++) begin : g_coef
      assign w_cin[gi]  = coef[gi*CW +: CW];
      assign w_creg[gi] = r_coef[gi*CW +: CW];
    end
  endgenerate

  assign w_deg_clamp = (deg > DW'(DEGREE)) ? DW'(DEGREE) : deg;
  assign w_start_c   = w_cin[w_deg_clamp];
  assign w_sel       = (r_idx == '0) ? '0 : r_idx - 1'b1;

  poly_mac_step #(.ACCW(ACCW), .XW(XW), .CW(CW)) u_mac (
    .i_acc (r_acc),
    .i_x   (r_x),
    .i_c   (w_creg[w_sel]),
    .o_res (w_mac)
  );

  assign w_acc_ext       = {{(MAXW-ACCW){r_acc[ACCW-1]}}, r_acc};
  assign w_sat           = saturate(w_acc_ext, YW, r_sat);
  assign unused_sat_bits = ^w_sat.value[MAXW-1:YW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    ready        = 1'b1;
    case (r_state)
      IDLE, DONE: begin
        if (enable) begin
          w_start      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        ready = 1'b0;
        if (r_idx != '0) begin
          w_step = 1'b1;
        end else begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_coef  <= '0;
      r_x     <= '0;
      r_sat   <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_start) begin
      r_coef  <= coef;
      r_x     <= x;
      r_sat   <= sat;
      r_idx   <= w_deg_clamp;
      r_acc   <= {{(ACCW-CW){w_start_c[CW-1]}}, w_start_c};
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_step) begin
      r_acc <= w_mac;
      r_idx <= r_idx - 1'b1;
    end else if (w_finish) begin
      r_y     <= w_sat.value[YW-1:0];
      r_ovf   <= w_sat.ovf;
      r_valid <= 1'b1;
    end
  end

  assign y     = r_y;
  assign valid = r_valid;
  assign ovf   = r_ovf;

endmodule

// File: doc/poly_horner_eval.md
Name: poly_horner_eval

Overview:
- Parametrised successor of the team's fixed quadratic evaluator (y = a·x² + b·x + c).
- Evaluates a signed polynomial of runtime-selectable degree, up to parameter DEGREE, by Horner's method: one multiply-accumulate per clock.
- Adds a wrap or saturate output mode and an overflow flag.
- Keeps the existing enable/ready/valid handshake, so the current file-driven bench drives it unchanged.
- At DEGREE=2, deg=2, sat=0 it matches the quadratic block bit-for-bit.

Parameters:
- XW, 8: signed width of x.
- CW, 16: signed width of each coefficient.
- YW, 16: signed width of y.
- DEGREE, 2: maximum polynomial degree, ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- x  in  XW  signed evaluation point.
- coef  in  (DEGREE+1)*CW  packed coefficients; coef[i*CW +: CW] = c_i, where c_0 is the constant term.
- deg  in  clog2(DEGREE+1)  runtime degree; values above DEGREE are clamped to DEGREE.
- sat  in  1  output mode: 1 = saturate, 0 = wrap (two's-complement truncation).
- enable  in  1  start request; sampled only when ready=1.
- y  out  YW  signed result.
- ready  out  1  block can accept enable.
- valid  out  1  y holds a completed result.
- ovf  out  1  full-precision result was outside the YW signed range.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; y=0, valid=0, ovf=0, ready=1.
  - Accumulator and index cleared.
  - Takes effect immediately, including mid-computation; the in-flight result is discarded.
- Internal accumulator width ACCW = CW + DEGREE*XW, enough to hold any result without loss.
- States: IDLE, RUN, DONE.
- IDLE/DONE, ready=1:
  - On a clock edge with enable=1, latch x, coef, clamped deg (D) and sat.
  - acc <= sext(c_D); idx <= D; ready <= 0; valid <= 0; ovf <= 0; state <= RUN.
- RUN, ready=0:
  - If idx≠0: acc <= acc*x + sext(c_{idx-1}); idx <= idx-1.
  - If idx=0: finalise acc into y and ovf, set valid <= 1, ready <= 1, state <= DONE.
- Latency: with enable sampled at edge k, valid and ready rise after edge k+D+1. D=2 gives 3 cycles; D=0 gives 1 cycle.
- Finalise:
  - ovf = (acc > 2^(YW-1)-1) or (acc < -2^(YW-1)).
  - sat=1: y is clamped to the max or min YW value.
  - sat=0: y = acc[YW-1:0].
  - If not ovf, y = acc in both modes.
- DONE: y, valid and ovf hold stable until the next accepted enable or reset.
- enable while ready=0 is ignored; no queuing, no effect on the current operation.
- enable held high:
  - Re-triggers on the first edge back in DONE.
  - valid is high for that one DONE cycle, then drops with the new start.
  - The bench must use enable as a pulse.
- Inputs are sampled only at start; changes to x, coef, deg or sat during RUN have no effect.
- Arithmetic is signed throughout; the multiply is ACCW × XW, truncated back to ACCW (cannot overflow by construction).

Decomposition:
- Package poly_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - function acc_width(CW, XW, DEGREE);
  - function saturate(acc, YW) returning value and ovf.
- One sub-module, poly_mac_step: combinational acc*x + c at ACCW, parameterised on ACCW/XW/CW.
- Coefficient select by idx and the FSM stay in poly_horner_eval.

Test Plan:
1. DEGREE=2, deg=2, sat=0, x=3, c2=2, c1=-5, c0=7 -> y=10, ovf=0; valid and ready rise exactly 3 cycles after the enable edge.
2. x=127, c2=32767, c1=0, c0=0, deg=2 -> sat=1: y=32767, ovf=1; sat=0: y=16639, ovf=1.
3. deg=1, x=-128, c1=300, c0=0, sat=1 -> y=-32768, ovf=1. Then deg=0, c0=-5 -> y=-5 with valid after 1 cycle.
4. DEGREE=4, deg=7 (clamped to 4), x=2, all c_i=1 -> y=31, latency 5 cycles. A second enable pulse during RUN is ignored, with the result and latency unchanged.
5. reset low one cycle mid-RUN -> y=0, valid=0, ovf=0, ready=1 asynchronously. A following start with case-1 inputs gives y=10.
6. Back-to-back file-driven vectors (bench style: enable pulse, wait valid, wait ready) over 1000 random x/coef/deg/sat -> all match the reference model.
